// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-segment scanner with a bus-mapped CTRL/OVR register pair.
// Define SEG7_BRIGHTNESS_EN to add the BRIGHT field and PWM digit gating.
module seg7_scan #(
  parameter int unsigned SCAN_DIV   = 36000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [6:0]  segments_out,
  output logic        dp_out,
  output logic [3:0]  digit_en_out
);

  localparam int unsigned  PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   ovr_q, ovr_d;
  logic          en_q, en_d;
  logic          src_q, src_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    den_q, den_d;

  logic          tick;
  logic          wr_ctrl;
  logic          wr_ovr;
  logic          pwm_on;
  logic [3:0]    bright_rd;
  logic [3:0]    nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  assign wr_ctrl = sel_in && !address_in[2];
  assign wr_ovr  = sel_in &&  address_in[2];
  assign tick    = (presc_q == PRESC_LAST);

  always_comb begin
    nib = snap_q[3:0];
    case (idx_q)
      2'd0: nib = snap_q[3:0];
      2'd1: nib = snap_q[7:4];
      2'd2: nib = snap_q[11:8];
      2'd3: nib = snap_q[15:12];
      default: nib = snap_q[3:0];
    endcase
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    // Snapshot samples the registers' current (pre-write) values.
    snap_d  = (tick && idx_q == 2'd3) ? (src_q ? ovr_q : bcd_in) : snap_q;

    en_d  = en_q;
    src_d = src_q;
    ovr_d = ovr_q;
    if (wr_ctrl && write_mask_in[0]) begin
      en_d  = write_value_in[0];
      src_d = write_value_in[1];
    end
    if (wr_ovr && write_mask_in[0]) ovr_d[7:0]  = write_value_in[7:0];
    if (wr_ovr && write_mask_in[1]) ovr_d[15:8] = write_value_in[15:8];

    seg_d = en_q ? seg_decode(nib) : '0;
    dp_d  = en_q && (idx_q == 2'd2) && !snap_q[0];
    den_d = (en_q && pwm_on) ? (4'b0001 << idx_q) : '0;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      ovr_q   <= '0;
      en_q    <= 1'b1;
      src_q   <= 1'b0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      den_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      ovr_q   <= ovr_d;
      en_q    <= en_d;
      src_q   <= src_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      den_q   <= den_d;
    end
  end

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0] pwm_q, pwm_d;
  logic [3:0] bright_q, bright_d;

  always_comb begin
    pwm_d    = pwm_q + 4'd1;
    bright_d = bright_q;
    if (wr_ctrl && write_mask_in[1]) bright_d = write_value_in[11:8];
  end

  assign pwm_on    = (pwm_q <= bright_q);
  assign bright_rd = bright_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pwm_q    <= '0;
      bright_q <= '1;
    end else begin
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
    end
  end
`else
  assign pwm_on    = 1'b1;
  assign bright_rd = '0;
`endif

  assign read_value_out = !sel_in      ? '0 :
                          address_in[2] ? {16'h0000, ovr_q} :
                                          {20'h00000, bright_rd, 6'h00, src_q, en_q};
  assign ready_out      = sel_in;

  assign segments_out = seg_q ^ {7{ACTIVE_LOW}};
  assign dp_out       = dp_q  ^ ACTIVE_LOW;
  assign digit_en_out = den_q ^ {4{ACTIVE_LOW}};

  logic unused_bits;
  assign unused_bits = ^{read_in, address_in[31:3], address_in[1:0],
                         write_value_in[31:16], write_mask_in[3:2]};

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan against a cycle-count based display model.
module tb_seg7_scan;

  localparam int unsigned D = 4;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] bcd_in = '0;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic        ready_out;
  logic [6:0]  segments_out;
  logic        dp_out;
  logic [3:0]  digit_en_out;

  seg7_scan #(.SCAN_DIV(D), .ACTIVE_LOW(1'b1)) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .bcd_in         (bcd_in),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .segments_out   (segments_out),
    .dp_out         (dp_out),
    .digit_en_out   (digit_en_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: after n clock edges out of reset the scan slot is (n/D)%4,
  // the PWM phase is n%16 and a new frame is captured every 4*D edges.
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  int unsigned m_n;
  int unsigned m_slot;
  logic [15:0] m_snap, m_ovr;
  logic        m_en, m_src;
  logic [3:0]  m_bright;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_den;

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_n = 0; m_snap = '0; m_ovr = '0; m_en = 1'b1; m_src = 1'b0; m_bright = 4'hF;
      e_seg = '0; e_dp = 1'b0; e_den = '0;
    end else begin
      m_slot = (m_n / D) % 4;
      e_seg  = m_en ? DEC[4'((m_snap >> (4 * m_slot)) & 16'hF)] : 7'h00;
      e_dp   = m_en && (m_slot == 2) && !m_snap[0];
      e_den  = (m_en && (m_n % 16) <= m_bright) ? 4'(1 << m_slot) : 4'h0;
      if (m_n % (4 * D) == 4 * D - 1) m_snap = m_src ? m_ovr : bcd_in;
      if (sel_in) begin
        if (address_in[2]) begin
          if (write_mask_in[0]) m_ovr[7:0]  = write_value_in[7:0];
          if (write_mask_in[1]) m_ovr[15:8] = write_value_in[15:8];
        end else begin
          if (write_mask_in[0]) {m_src, m_en} = write_value_in[1:0];
`ifdef SEG7_BRIGHTNESS_EN
          if (write_mask_in[1]) m_bright = write_value_in[11:8];
`endif
        end
      end
      m_n++;
    end
  end

  function automatic logic [31:0] model_ctrl();
`ifdef SEG7_BRIGHTNESS_EN
    return {20'd0, m_bright, 6'd0, m_src, m_en};
`else
    return {30'd0, m_src, m_en};
`endif
  endfunction

  logic chk_on = 1'b0;
  always @(negedge clk_in) begin
    if (chk_on && !reset) begin
      check_eq("seg", segments_out, e_seg ^ 7'h7F);
      check_eq("dp",  dp_out,       e_dp ^ 1'b1);
      check_eq("den", digit_en_out, e_den ^ 4'hF);
    end
  end

  task automatic idle(input int unsigned cycles);
    repeat (cycles) @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m);
    @(posedge clk_in); #1;
    address_in = a; write_value_in = v; write_mask_in = m; sel_in = 1'b1; read_in = 1'b0;
    @(posedge clk_in); #1;
    sel_in = 1'b0; write_mask_in = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input bit use_model);
    logic [31:0] e;
    @(posedge clk_in); #1;
    address_in = a; sel_in = 1'b1; read_in = 1'b1; write_mask_in = '0;
    #1;
    e = use_model ? (a[2] ? {16'd0, m_ovr} : model_ctrl()) : exp;
    check_eq(tag, read_value_out, e);
    check_eq("ready", ready_out, 1'b1);
    sel_in = 1'b0; read_in = 1'b0;
    #1;
    check_eq("rd_idle", read_value_out, 32'h0);
  endtask

  task automatic wait_slot(input string tag, input int unsigned d, input logic [6:0] seg, input logic dp_act);
    logic [3:0] pat;
    logic       found;
    pat   = 4'hF ^ 4'(1 << d);
    found = 1'b0;
    for (int i = 0; i < 8 * D && !found; i++) begin
      @(negedge clk_in);
      if (digit_en_out == pat) begin
        found = 1'b1;
        check_eq(tag, segments_out, seg ^ 7'h7F);
        check_eq({tag, "_dp"}, dp_out, dp_act ^ 1'b1);
      end
    end
    check_eq({tag, "_seen"}, found, 1'b1);
  endtask

  logic [31:0] v;
  logic [31:0] ctrl_f01, ctrl_301;

  initial begin
`ifdef SEG7_BRIGHTNESS_EN
    ctrl_f01 = 32'h0F01; ctrl_301 = 32'h0301;
`else
    ctrl_f01 = 32'h0001; ctrl_301 = 32'h0001;
`endif
    repeat (2) @(posedge clk_in);
    #1;
    check_eq("rst_seg", segments_out, 7'h7F);
    check_eq("rst_den", digit_en_out, 4'hF);
    check_eq("rst_dp",  dp_out,       1'b1);
    check_eq("rst_rd",  read_value_out, 32'h0);
    reset  = 1'b0;
    chk_on = 1'b1;
    rd("ctrl_rst", 32'h0, ctrl_f01, 1'b0);
    rd("ovr_rst",  32'h4, 32'h0,    1'b0);

    bcd_in = 16'h1259;
    idle(8 * D);
    wait_slot("live0", 0, 7'h6F, 1'b0);
    wait_slot("live1", 1, 7'h6D, 1'b0);
    wait_slot("live2", 2, 7'h5B, 1'b0);
    wait_slot("live3", 3, 7'h06, 1'b0);

    bcd_in = 16'h0959;
    idle(8 * D);
    wait_slot("tear_pre1", 1, 7'h6D, 1'b0);
    @(posedge clk_in); #1;
    bcd_in = 16'h1000;
    wait_slot("tear_old3", 3, 7'h3F, 1'b0);
    wait_slot("tear_new2", 2, 7'h3F, 1'b1);
    wait_slot("tear_new3", 3, 7'h06, 1'b0);

    wr(32'h4, 32'h0000_A042, 4'b0011);
    wr(32'h0, 32'h0000_0F03, 4'b0011);
    rd("ovr_rd", 32'h4, 32'h0000_A042, 1'b0);
    idle(8 * D);
    wait_slot("ovr0", 0, 7'h5B, 1'b0);
    wait_slot("ovr2", 2, 7'h3F, 1'b1);
    wait_slot("ovr3", 3, 7'h40, 1'b0);

    wr(32'h0, 32'h0000_0F01, 4'b0011);
    wr(32'h0, 32'hFFFF_FFFF, 4'b0010);
    rd("mask_ff", 32'h0, ctrl_f01, 1'b0);
    wr(32'h0, 32'h0000_0300, 4'b0010);
    rd("mask_03", 32'h0, ctrl_301, 1'b0);
    idle(64);

    wr(32'h0, 32'h0000_0F00, 4'b0011);
    idle(12 * D);
    wr(32'h0, 32'h0000_0F01, 4'b0011);
    idle(4 * D);

    @(posedge clk_in); #3;
    reset = 1'b1;
    #1;
    check_eq("amid_seg", segments_out, 7'h7F);
    check_eq("amid_den", digit_en_out, 4'hF);
    check_eq("amid_dp",  dp_out,       1'b1);
    @(posedge clk_in); #1;
    reset = 1'b0;
    rd("ctrl_rst2", 32'h0, ctrl_f01, 1'b0);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: bcd_in = 16'($urandom);
        1: begin
          v = $urandom;
          if ($urandom_range(0, 3) != 0) v[0] = 1'b1;
          wr({29'd0, 1'($urandom_range(0, 1)), 2'd0}, v, 4'($urandom));
        end
        2: rd("rand_rd", {29'd0, 1'($urandom_range(0, 1)), 2'd0}, 32'h0, 1'b1);
        default: idle($urandom_range(1, 2 * D));
      endcase
      idle($urandom_range(0, D));
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
